// File: rtl/ci_integrator_driver.sv
// Initiator for the Nios II multicycle custom-instruction handshake: one transaction per
// sample (dataa = sample, datab = accumulator), result written back and streamed out.
// Optional macro CI_TIMEOUT_EN enables the WAIT-state abort timer and sticky timeout_err.
module ci_integrator_driver #(
  parameter int unsigned       DATA_W         = 32,
  parameter int unsigned       TIMEOUT_CYCLES = 64,
  parameter logic [DATA_W-1:0] ACC_INIT       = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              ci_clk_en,
  output logic              ci_start,
  output logic [DATA_W-1:0] ci_dataa,
  output logic [DATA_W-1:0] ci_datab,
  input  logic              ci_done,
  input  logic [DATA_W-1:0] ci_result,
  output logic              r_valid,
  input  logic              r_ready,
  output logic [DATA_W-1:0] r_data,
  input  logic              clear,
  output logic              busy,
  output logic              timeout_err
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_OUTPUT = 2'd3
  } state_t;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("ci_integrator_driver: TIMEOUT_CYCLES must be >= 2");
  end

  state_t            state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] dataa_q, dataa_d;
  logic [DATA_W-1:0] datab_q, datab_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              clr_pend_q, clr_pend_d;
  logic              s_ready_q, ci_start_q, ci_clk_en_q, r_valid_q, busy_q;
  logic              clr_now_s;
  logic              timeout_hit_s;

`ifdef CI_TIMEOUT_EN
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES);

  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             tmo_err_q, tmo_err_d;

  // WAIT-state timer: cleared in ISSUE, aborts on the last allowed WAIT cycle.
  always_comb begin
    tmr_d         = tmr_q;
    timeout_hit_s = 1'b0;
    if (state_q == ST_ISSUE) begin
      tmr_d = '0;
    end else if ((state_q == ST_WAIT) && !ci_done) begin
      if (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
        timeout_hit_s = 1'b1;
      end else begin
        tmr_d = tmr_q + TMR_W'(1);
      end
    end else begin
      tmr_d = tmr_q;
    end
    tmo_err_d = tmo_err_q | timeout_hit_s;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmr_q     <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      tmr_q     <= tmr_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  assign timeout_err = tmo_err_q;
`else
  assign timeout_hit_s = 1'b0;
  assign timeout_err   = 1'b0;
`endif

  // A clear seen this cycle or earlier wins over a same-cycle sample handshake in IDLE.
  assign clr_now_s = clr_pend_q | clear;

  // Next-state and datapath decode.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    dataa_d    = dataa_q;
    datab_d    = datab_q;
    rdata_d    = rdata_q;
    clr_pend_d = clr_pend_q | clear;
    case (state_q)
      ST_IDLE: begin
        if (clr_now_s) begin
          acc_d      = ACC_INIT;
          clr_pend_d = 1'b0;
        end else begin
          acc_d = acc_q;
        end
        if (s_valid && s_ready_q) begin
          dataa_d = s_data;
          datab_d = clr_now_s ? ACC_INIT : acc_q;
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (ci_done) begin
          acc_d   = ci_result;
          rdata_d = ci_result;
          state_d = ST_OUTPUT;
        end else if (timeout_hit_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_OUTPUT: begin
        if (r_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_OUTPUT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, datapath and output registers; outputs decoded from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      acc_q       <= ACC_INIT;
      dataa_q     <= '0;
      datab_q     <= '0;
      rdata_q     <= '0;
      clr_pend_q  <= 1'b0;
      s_ready_q   <= 1'b1;
      ci_start_q  <= 1'b0;
      ci_clk_en_q <= 1'b0;
      r_valid_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      dataa_q     <= dataa_d;
      datab_q     <= datab_d;
      rdata_q     <= rdata_d;
      clr_pend_q  <= clr_pend_d;
      s_ready_q   <= (state_d == ST_IDLE);
      ci_start_q  <= (state_d == ST_ISSUE);
      ci_clk_en_q <= (state_d == ST_ISSUE) || (state_d == ST_WAIT);
      r_valid_q   <= (state_d == ST_OUTPUT);
      busy_q      <= (state_d != ST_IDLE);
    end
  end

  assign s_ready   = s_ready_q;
  assign ci_start  = ci_start_q;
  assign ci_clk_en = ci_clk_en_q;
  assign ci_dataa  = dataa_q;
  assign ci_datab  = datab_q;
  assign r_valid   = r_valid_q;
  assign r_data    = rdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_ci_integrator_driver.sv
// Self-checking bench for ci_integrator_driver: behavioural accumulator model plus an
// adder slave on the custom-instruction port, randomized samples, latencies and backpressure.
module tb_ci_integrator_driver;

  localparam int DW = 32;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          ci_clk_en, ci_start;
  logic [DW-1:0] ci_dataa, ci_datab;
  logic          ci_done = 1'b0;
  logic [DW-1:0] ci_result = '0;
  logic          r_valid;
  logic          r_ready = 1'b0;
  logic [DW-1:0] r_data;
  logic          clear = 1'b0;
  logic          busy, timeout_err;

  int            n_chk = 0;
  int            n_fail = 0;
  logic [DW-1:0] m_acc = '0;

  ci_integrator_driver #(.DATA_W(DW), .TIMEOUT_CYCLES(TO), .ACC_INIT('0)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .ci_clk_en(ci_clk_en), .ci_start(ci_start), .ci_dataa(ci_dataa), .ci_datab(ci_datab),
    .ci_done(ci_done), .ci_result(ci_result),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data),
    .clear(clear), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction. clr_mode: 0 none, 1 clear pulsed in WAIT, 2 clear with the sample.
  task automatic do_txn(input logic [DW-1:0] sample, input int lat, input int rdelay,
                        input int clr_mode, input bit stray);
    logic [DW-1:0] exp_b, exp_r;
    int n;
    s_data  = sample;
    s_valid = 1'b1;
    if (clr_mode == 2) clear = 1'b1;
    n = 0;
    while (s_ready !== 1'b1 && n < 50) begin tick(); n++; end
    n_chk++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL s_ready_wait: got %b want 1", s_ready); end
    if (stray) begin ci_done = 1'b1; ci_result = 32'hDEADBEEF; end
    exp_b = (clr_mode == 2) ? '0 : m_acc;
    exp_r = sample + exp_b;
    tick();
    s_valid = 1'b0;
    clear   = 1'b0;
    n_chk++; if (ci_start !== 1'b1 || ci_clk_en !== 1'b1) begin n_fail++; $display("FAIL issue_strobe: start=%b clk_en=%b want 1/1", ci_start, ci_clk_en); end
    n_chk++; if (ci_dataa !== sample) begin n_fail++; $display("FAIL issue_dataa: got %h want %h", ci_dataa, sample); end
    n_chk++; if (ci_datab !== exp_b) begin n_fail++; $display("FAIL issue_datab: got %h want %h", ci_datab, exp_b); end
    n_chk++; if (busy !== 1'b1 || s_ready !== 1'b0) begin n_fail++; $display("FAIL issue_busy: busy=%b s_ready=%b want 1/0", busy, s_ready); end
    if (!stray) ci_done = 1'b0;
    tick();
    ci_done = 1'b0;
    n_chk++; if (ci_start !== 1'b0 || ci_clk_en !== 1'b1 || r_valid !== 1'b0) begin n_fail++; $display("FAIL wait_entry: start=%b clk_en=%b r_valid=%b want 0/1/0", ci_start, ci_clk_en, r_valid); end
    if (clr_mode == 1) clear = 1'b1;
    for (int i = 0; i < lat; i++) begin
      tick();
      clear = 1'b0;
      n_chk++; if (ci_clk_en !== 1'b1 || ci_start !== 1'b0 || ci_dataa !== sample || ci_datab !== exp_b) begin n_fail++; $display("FAIL wait_hold: clk_en=%b start=%b a=%h b=%h want 1/0/%h/%h", ci_clk_en, ci_start, ci_dataa, ci_datab, sample, exp_b); end
    end
    ci_done   = 1'b1;
    ci_result = ci_dataa + ci_datab;
    tick();
    ci_done = 1'b0;
    clear   = 1'b0;
    n_chk++; if (r_valid !== 1'b1 || r_data !== exp_r) begin n_fail++; $display("FAIL output: r_valid=%b r_data=%h want 1/%h", r_valid, r_data, exp_r); end
    n_chk++; if (ci_clk_en !== 1'b0) begin n_fail++; $display("FAIL output_clk_en: got %b want 0", ci_clk_en); end
    if (stray) begin ci_done = 1'b1; ci_result = 32'hDEADBEEF; end
    for (int i = 0; i < rdelay; i++) begin
      tick();
      n_chk++; if (r_valid !== 1'b1 || r_data !== exp_r || s_ready !== 1'b0 || ci_start !== 1'b0) begin n_fail++; $display("FAIL backpressure: r_valid=%b r_data=%h s_ready=%b start=%b want 1/%h/0/0", r_valid, r_data, s_ready, ci_start, exp_r); end
    end
    r_ready = 1'b1;
    tick();
    r_ready = 1'b0;
    ci_done = 1'b0;
    n_chk++; if (r_valid !== 1'b0 || s_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL return_idle: r_valid=%b s_ready=%b busy=%b want 0/1/0", r_valid, s_ready, busy); end
    m_acc = (clr_mode == 1) ? '0 : exp_r;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    n_chk++; if (s_ready !== 1'b1 || ci_clk_en !== 1'b0 || ci_start !== 1'b0 || r_valid !== 1'b0 || busy !== 1'b0 || timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_ctrl: s_ready=%b clk_en=%b start=%b r_valid=%b busy=%b terr=%b want 1/0/0/0/0/0", s_ready, ci_clk_en, ci_start, r_valid, busy, timeout_err); end
    n_chk++; if (ci_dataa !== '0 || ci_datab !== '0 || r_data !== '0) begin n_fail++; $display("FAIL reset_data: a=%h b=%h r=%h want 0/0/0", ci_dataa, ci_datab, r_data); end
    #2 reset_n = 1'b1;
    tick();
    m_acc = '0;
    n_chk++; if (s_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: s_ready=%b busy=%b want 1/0", s_ready, busy); end
  endtask

  task automatic test_basic();
    do_txn(32'd5, 0, 0, 0, 1'b0);
    do_txn(32'd7, 0, 0, 0, 1'b0);
    do_txn(32'd10, 0, 10, 0, 1'b0);
    n_chk++; if (r_data !== 32'd22) begin n_fail++; $display("FAIL basic_sum: got %0d want 22", r_data); end
  endtask

  task automatic test_timeout();
    int n;
    logic [DW-1:0] exp_r;
`ifdef CI_TIMEOUT_EN
    s_data = 32'd100; s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    tick();
    n_chk++; if (timeout_err !== 1'b0 || ci_clk_en !== 1'b1) begin n_fail++; $display("FAIL timeout_pre: terr=%b clk_en=%b want 0/1", timeout_err, ci_clk_en); end
    n = 0;
    while (busy === 1'b1 && n < 200) begin tick(); n++; end
    n_chk++; if (n !== TO) begin n_fail++; $display("FAIL timeout_cycles: got %0d want %0d", n, TO); end
    n_chk++; if (timeout_err !== 1'b1 || r_valid !== 1'b0 || s_ready !== 1'b1) begin n_fail++; $display("FAIL timeout_abort: terr=%b r_valid=%b s_ready=%b want 1/0/1", timeout_err, r_valid, s_ready); end
    do_txn(32'd3, 0, 0, 0, 1'b0);
    n_chk++; if (r_data !== m_acc || timeout_err !== 1'b1) begin n_fail++; $display("FAIL timeout_after: r_data=%0d terr=%b want %0d/1", r_data, timeout_err, m_acc); end
`else
    s_data = 32'd3; s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    tick();
    for (int i = 0; i < TO + 10; i++) tick();
    n_chk++; if (busy !== 1'b1 || ci_clk_en !== 1'b1 || timeout_err !== 1'b0) begin n_fail++; $display("FAIL wait_forever: busy=%b clk_en=%b terr=%b want 1/1/0", busy, ci_clk_en, timeout_err); end
    exp_r = m_acc + 32'd3;
    ci_done = 1'b1; ci_result = ci_dataa + ci_datab;
    tick();
    ci_done = 1'b0;
    n_chk++; if (r_valid !== 1'b1 || r_data !== exp_r) begin n_fail++; $display("FAIL late_done: r_valid=%b r_data=%0d want 1/%0d", r_valid, r_data, exp_r); end
    r_ready = 1'b1; tick(); r_ready = 1'b0;
    m_acc = exp_r;
    n = 0;
`endif
  endtask

  task automatic test_stray_done();
    do_txn(32'd11, 1, 2, 0, 1'b1);
    do_txn(32'd2, 0, 0, 0, 1'b0);
  endtask

  task automatic test_clear();
    do_txn(32'd4, 2, 0, 1, 1'b0);
    do_txn(32'd1, 0, 0, 0, 1'b0);
    n_chk++; if (r_data !== 32'd1) begin n_fail++; $display("FAIL clear_result: got %0d want 1", r_data); end
    do_txn(32'd8, 0, 1, 0, 1'b0);
    do_txn(32'd6, 0, 0, 2, 1'b0);
  endtask

  task automatic test_random();
    int cm;
    for (int t = 0; t < 25; t++) begin
      cm = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0;
      do_txn($urandom, int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), cm, ($urandom_range(0, 3) == 0));
    end
  endtask

  task automatic test_reset_mid();
    s_data = 32'd55; s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    tick();
    tick();
    #2 reset_n = 1'b0;
    #1;
    n_chk++; if (ci_start !== 1'b0 || ci_clk_en !== 1'b0 || r_valid !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b1) begin n_fail++; $display("FAIL async_reset: start=%b clk_en=%b r_valid=%b busy=%b s_ready=%b want 0/0/0/0/1", ci_start, ci_clk_en, r_valid, busy, s_ready); end
    #2 reset_n = 1'b1;
    m_acc = '0;
    tick();
    do_txn(32'd9, 0, 0, 0, 1'b0);
    n_chk++; if (r_data !== 32'd9) begin n_fail++; $display("FAIL after_reset_result: got %0d want 9", r_data); end
  endtask

  task automatic test_back_to_back();
    s_valid = 1'b1; s_data = 32'd20;
    tick();
    n_chk++; if (ci_start !== 1'b1) begin n_fail++; $display("FAIL b2b_start: got %b want 1", ci_start); end
    tick();
    ci_done = 1'b1; ci_result = ci_dataa + ci_datab;
    r_ready = 1'b1;
    tick();
    ci_done = 1'b0;
    n_chk++; if (r_valid !== 1'b1 || r_data !== m_acc + 32'd20 || s_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_out: r_valid=%b r_data=%0d s_ready=%b want 1/%0d/0", r_valid, r_data, s_ready, m_acc + 32'd20); end
    m_acc = m_acc + 32'd20;
    tick();
    n_chk++; if (s_ready !== 1'b1 || r_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: s_ready=%b r_valid=%b want 1/0", s_ready, r_valid); end
    r_ready = 1'b0;
    s_data = 32'd30;
    tick();
    s_valid = 1'b0;
    n_chk++; if (ci_start !== 1'b1 || ci_datab !== m_acc) begin n_fail++; $display("FAIL b2b_second: start=%b b=%0d want 1/%0d", ci_start, ci_datab, m_acc); end
    tick();
    ci_done = 1'b1; ci_result = ci_dataa + ci_datab;
    tick();
    ci_done = 1'b0;
    n_chk++; if (r_data !== m_acc + 32'd30) begin n_fail++; $display("FAIL b2b_second_out: got %0d want %0d", r_data, m_acc + 32'd30); end
    m_acc = m_acc + 32'd30;
    r_ready = 1'b1; tick(); r_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_stray_done();
    test_clear();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ci_integrator_driver.md
Name: ci_integrator_driver

Overview:
- Initiator side of the Nios II multicycle custom-instruction handshake (clk_en/start/done/dataa/datab/result).
- Accepts a stream of sensor samples and issues one custom-instruction transaction per sample: dataa = sample, datab = running accumulator.
- Writes each returned result back as the new accumulator and forwards it on an output stream.
- Sits between the sample source (SPI/accelerometer FIFO) and the integrator custom instruction, so integration runs without CPU involvement.

Parameters:
- DATA_W, 32: width of samples, accumulator and custom-instruction data buses.
- TIMEOUT_CYCLES, 64: maximum cycles spent in WAIT before abort; must be >= 2.
- ACC_INIT, 0: accumulator value after reset and after clear.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- s_valid  in  1  sample available.
- s_ready  out  1  driver can accept a sample.
- s_data  in  DATA_W  sample value.
- ci_clk_en  out  1  custom-instruction clock enable.
- ci_start  out  1  one-cycle transaction start.
- ci_dataa  out  DATA_W  operand A (sample).
- ci_datab  out  DATA_W  operand B (accumulator).
- ci_done  in  1  slave completion strobe.
- ci_result  in  DATA_W  slave result; valid only when ci_done=1.
- r_valid  out  1  result available.
- r_ready  in  1  consumer accepts result.
- r_data  out  DATA_W  integrated value.
- clear  in  1  synchronous request to reload the accumulator with ACC_INIT.
- busy  out  1  high in any state other than IDLE.
- timeout_err  out  1  sticky abort flag; cleared only by reset.

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low (clk, reset_n).
- Reset values: state=IDLE; acc=ACC_INIT; s_ready=1, ci_clk_en=0, ci_start=0, r_valid=0, busy=0, timeout_err=0; ci_dataa=0, ci_datab=0, r_data=0.
- FSM states: IDLE, ISSUE, WAIT, OUTPUT.
- IDLE:
  - s_ready=1.
  - On s_valid & s_ready: latch s_data into ci_dataa and acc into ci_datab, then go to ISSUE.
- ISSUE:
  - ci_start=1 and ci_clk_en=1 for exactly one cycle.
  - Timer cleared; go to WAIT.
- WAIT:
  - ci_clk_en=1; ci_dataa and ci_datab held stable.
  - On ci_done=1: acc <= ci_result, r_data <= ci_result, go to OUTPUT.
  - Otherwise the timer increments. When the timer reaches TIMEOUT_CYCLES-1 without done: set timeout_err, go to IDLE, leave acc unchanged, drop the sample.
- OUTPUT:
  - r_valid=1 and r_data held until r_ready.
  - On r_valid & r_ready: go to IDLE.
- ci_done sampled only in WAIT. A done in IDLE, ISSUE or OUTPUT is ignored; a stray done never corrupts acc.
- ci_clk_en=0 in IDLE and OUTPUT.
- Minimum latency: sample handshake at cycle T → ci_start at T+1 → done earliest at T+2 → r_valid at T+3. Throughput is at most one sample per 4 cycles.
- clear:
  - Sampled every cycle into a pending flag.
  - Applied on the cycle the FSM is in IDLE (acc <= ACC_INIT), before a sample handshake in that same cycle. The same-cycle sample therefore uses ACC_INIT as datab.
  - clear during WAIT/OUTPUT: the in-flight result is still output on r_data, but acc is reset once IDLE is reached.
- Arithmetic: none inside the driver; ci_result is taken verbatim (wrap-around is the slave's concern).
- Reset mid-transaction: all state is abandoned immediately; ci_start/ci_clk_en drop asynchronously; no output is produced.

Optional Feature:
- Macro: CI_TIMEOUT_EN.
- Defined: WAIT timeout, timer and timeout_err behave as above.
- Undefined: no timer; WAIT holds indefinitely until ci_done; timeout_err tied to 0; TIMEOUT_CYCLES unused.

Test Plan:
- Reset, slave returns dataa+datab with 1-cycle done, samples 5, 7, 10 → r_data 5, 12, 22; r_valid 3 cycles after each accepted sample.
- r_ready held low 10 cycles in OUTPUT → r_data stays 22, s_ready=0 and no ci_start throughout; release → next sample accepted.
- Slave never asserts done (CI_TIMEOUT_EN, TIMEOUT_CYCLES=64) → timeout_err=1 after 64 WAIT cycles, acc unchanged (22); next sample 3 → r_data 25.
- Stray ci_done pulsed in IDLE and ISSUE with ci_result=0xDEADBEEF → ignored; the following transaction output is correct.
- clear pulsed during WAIT of sample 4 (acc 22) → r_data 26 output, then next sample 1 → r_data 1.
- reset_n low during WAIT → ci_start/ci_clk_en/r_valid/busy=0 asynchronously; after release the first sample 9 → r_data 9.
